// File: rtl/mp_pkg.sv
// Shared types and constants for the mp_sequencer program sequencer:
// FSM states, opcodes, ALU function codes and instruction field positions.
package mp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FETCH = 2'd2,
    ST_EXEC  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDI  = 3'b001,
    OP_ALU  = 3'b010,
    OP_JMP  = 3'b011,
    OP_JZ   = 3'b100,
    OP_HALT = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } opcode_t;

  localparam logic [2:0] FN_ADD   = 3'b000;
  localparam logic [2:0] FN_SUB   = 3'b001;
  localparam logic [2:0] FN_AND   = 3'b010;
  localparam logic [2:0] FN_OR    = 3'b011;
  localparam logic [2:0] FN_XOR   = 3'b100;
  localparam logic [2:0] FN_PASSB = 3'b101;
  localparam logic [2:0] FN_INC   = 3'b110;
  localparam logic [2:0] PASS_IMM = 3'b111;

  localparam int OP_MSB = 11;
  localparam int OP_LSB = 9;
  localparam int RD_MSB = 8;
  localparam int RD_LSB = 7;
  localparam int RS_MSB = 6;
  localparam int RS_LSB = 5;
  localparam int FN_MSB = 4;
  localparam int FN_LSB = 2;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mp_decode.sv
// Combinational instruction decoder: turns the held instruction into the
// datapath control bus and branch/halt/illegal flags, all gated by exec_en.
module mp_decode
  import mp_pkg::*;
(
  input  logic                i_exec_en,
  input  logic [OP_MSB:FN_LSB] i_ir,
  output logic [3:0]          o_ce,
  output logic [2:0]          o_w,
  output logic [1:0]          o_sel,
  output logic [2:0]          o_s,
  output logic                o_is_jmp,
  output logic                o_is_jz,
  output logic                o_is_halt,
  output logic                o_is_illegal
);

  opcode_t    w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [2:0] w_fn;

  assign w_op = opcode_t'(i_ir[OP_MSB:OP_LSB]);
  assign w_rd = i_ir[RD_MSB:RD_LSB];
  assign w_rs = i_ir[RS_MSB:RS_LSB];
  assign w_fn = i_ir[FN_MSB:FN_LSB];

  always_comb begin
    o_ce         = 4'b0000;
    o_w          = 3'b000;
    o_sel        = 2'b00;
    o_s          = 3'b000;
    o_is_jmp     = 1'b0;
    o_is_jz      = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    if (i_exec_en) begin
      case (w_op)
        OP_LDI: begin
          o_ce = onehot4(w_rd);
          o_w  = w_fn;
          o_s  = PASS_IMM;
        end
        OP_ALU: begin
          o_ce  = onehot4(w_rd);
          o_sel = w_rs;
          o_s   = w_fn;
        end
        OP_JMP:  o_is_jmp  = 1'b1;
        OP_JZ:   o_is_jz   = 1'b1;
        OP_HALT: o_is_halt = 1'b1;
        OP_ILL6, OP_ILL7: o_is_illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mp_sequencer.sv
// Program sequencer: IDLE -> CLEAR -> (FETCH -> EXEC)* until HALT or an
// illegal opcode. Control outputs are Moore, derived from state and ir only.
module mp_sequencer
  import mp_pkg::*;
#(
  parameter int PC_W = 4,
  parameter int IW   = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [IW-1:0]   instr_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] pc_o,
  output logic            clr_o,
  output logic [3:0]      ce_o,
  output logic [2:0]      w_o,
  output logic [1:0]      sel_o,
  output logic [2:0]      s_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [IW-1:0]   r_ir;
  logic            r_err;

  state_t          w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic            w_ir_load;
  logic            w_err_set;
  logic            w_err_clr;

  logic            w_exec;
  logic            w_is_jmp;
  logic            w_is_jz;
  logic            w_is_halt;
  logic            w_is_illegal;
  logic [PC_W-1:0] w_target;

  assign w_exec   = (r_state == ST_EXEC);
  assign w_target = r_ir[PC_W-1:0];

  mp_decode u_decode (
    .i_exec_en    (w_exec),
    .i_ir         (r_ir[OP_MSB:FN_LSB]),
    .o_ce         (ce_o),
    .o_w          (w_o),
    .o_sel        (sel_o),
    .o_s          (s_o),
    .o_is_jmp     (w_is_jmp),
    .o_is_jz      (w_is_jz),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_load   = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_CLEAR;
          w_pc_nxt    = '0;
          w_err_clr   = 1'b1;
        end
      end
      ST_CLEAR: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        w_ir_load   = 1'b1;
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        // HALT and illegal leave pc where it stopped for post-mortem
        if (w_is_halt) begin
          w_state_nxt = ST_IDLE;
        end else if (w_is_illegal) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_is_jmp || (w_is_jz && zero_i)) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_FETCH;
        end else begin
          w_pc_nxt    = r_pc + PC_W'(1);
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_ir_load) r_ir <= instr_i;
      if (w_err_set) r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
    end
  end

  assign pc_o   = r_pc;
  assign clr_o  = (r_state == ST_CLEAR);
  assign busy_o = (r_state != ST_IDLE);
  assign done_o = w_is_halt;
  assign err_o  = r_err;

endmodule
